frame_pattern_tx: RTL

- Video-source transmitter: generates fval/lval/dval framing plus 8-bit greyscale test-pattern pixels.
- Drives the same parallel camera-style interface that the frame capture block records to file; pattern chosen by sel.
- Sits at the head of the simulation pipeline as the stimulus source for capture and downstream video blocks.
- Synthesizable, fully registered outputs.

---
 rtl/frame_pattern_tx.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/frame_pattern_tx.sv
// Camera-style video source: fval/lval/dval framing with selectable 8-bit
// greyscale test patterns. All outputs come straight from flops.
module frame_pattern_tx #(
    parameter int WIDTH   = 640,
    parameter int HEIGHT  = 480,
    parameter int H_BLANK = 16,
    parameter int V_FRONT = 8,
    parameter int V_BACK  = 8,
    parameter int F_BLANK = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [2:0]  sel,
    output logic        fval,
    output logic        lval,
    output logic        dval,
    output logic [7:0]  pix_data,
    output logic        frame_done,
    output logic [15:0] frame_cnt,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_VFRONT = 3'd1,
        S_LINE   = 3'd2,
        S_HBLANK = 3'd3,
        S_VBACK  = 3'd4,
        S_FBLANK = 3'd5
    } state_t;

    localparam logic [15:0] W_LAST  = 16'(WIDTH - 1);
    localparam logic [15:0] H_LAST  = 16'(HEIGHT - 1);
    localparam logic [15:0] HB_LAST = 16'(H_BLANK - 1);
    localparam logic [15:0] VF_LAST = 16'(V_FRONT - 1);
    localparam logic [15:0] VB_LAST = 16'(V_BACK - 1);
    localparam logic [15:0] FB_LAST = 16'(F_BLANK - 1);

    state_t      state_q, state_d;
    logic [15:0] x_q, x_d, y_q, y_d, cnt_q, cnt_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic [2:0]  sel_q, sel_d;
    logic        fval_q, fval_d, lval_q, lval_d, done_q, done_d;
    logic [7:0]  pix_q, pix_d;

    function automatic logic [7:0] pattern(input logic [2:0] s,
                                           input logic [15:0] px,
                                           input logic [15:0] py);
        logic [7:0] p;
        p = 8'h80;
        case (s)
            3'b000: p = px[6] ? 8'hFF : 8'h00;
            3'b001: p = py[4] ? 8'hC0 : 8'h40;
            3'b010: p = px[7:0];
            3'b011: p = (px[4] ^ py[4]) ? 8'hFF : 8'h00;
            3'b110: p = (px[6] ^ py[6]) ? {px[5:0], 2'b00} : {py[5:0], 2'b00};
            3'b111: p = px[7:0] ^ py[7:0];
            default: p = 8'h80;
        endcase
        return p;
    endfunction

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        cnt_d       = cnt_q;
        sel_d       = sel_q;
        frame_cnt_d = frame_cnt_q;
        done_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (en) begin
                    state_d = S_VFRONT;
                    sel_d   = sel;
                    cnt_d   = '0;
                    x_d     = '0;
                    y_d     = '0;
                end
            end
            S_VFRONT: begin
                if (cnt_q == VF_LAST) begin
                    state_d = S_LINE;
                    x_d     = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_LINE: begin
                if (x_q == W_LAST) begin
                    cnt_d   = '0;
                    state_d = (y_q == H_LAST) ? S_VBACK : S_HBLANK;
                end else begin
                    x_d = x_q + 16'd1;
                end
            end
            S_HBLANK: begin
                if (cnt_q == HB_LAST) begin
                    state_d = S_LINE;
                    x_d     = '0;
                    y_d     = y_q + 16'd1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_VBACK: begin
                // Frame completion is counted on the edge that drops fval.
                if (cnt_q == VB_LAST) begin
                    state_d     = S_FBLANK;
                    cnt_d       = '0;
                    done_d      = 1'b1;
                    frame_cnt_d = frame_cnt_q + 16'd1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_FBLANK: begin
                if (cnt_q == FB_LAST) begin
                    cnt_d = '0;
                    if (en) begin
                        state_d = S_VFRONT;
                        sel_d   = sel;
                        x_d     = '0;
                        y_d     = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered from next-state values, so they align with state_q.
        fval_d = (state_d == S_VFRONT) || (state_d == S_LINE) ||
                 (state_d == S_HBLANK) || (state_d == S_VBACK);
        lval_d = (state_d == S_LINE);
        pix_d  = lval_d ? pattern(sel_d, x_d, y_d) : 8'h00;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            x_q         <= '0;
            y_q         <= '0;
            cnt_q       <= '0;
            sel_q       <= '0;
            frame_cnt_q <= '0;
            fval_q      <= 1'b0;
            lval_q      <= 1'b0;
            done_q      <= 1'b0;
            pix_q       <= 8'h00;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            cnt_q       <= cnt_d;
            sel_q       <= sel_d;
            frame_cnt_q <= frame_cnt_d;
            fval_q      <= fval_d;
            lval_q      <= lval_d;
            done_q      <= done_d;
            pix_q       <= pix_d;
        end
    end

    assign fval       = fval_q;
    assign lval       = lval_q;
    assign dval       = lval_q;
    assign pix_data   = pix_q;
    assign frame_done = done_q;
    assign frame_cnt  = frame_cnt_q;
    assign dbg_state  = state_q;

endmodule
